sd_dat_rx_deframer: RTL and testbench

Front end of the SD card read data path, clocked by the card clock wclk. Watches the four DAT lines for a start bit, then strips the block framing (start bit, per-line CRC16, end bit). Forwards payload nibbles with a write strobe directly into the 4-bit write port of the RX word-packing FIFO. Supports multi-block reads and reports CRC, end-bit, timeout and overrun status to the host-side controller.

---
 rtl/sd_dat_rx_deframer_pkg.sv | 26 ++
 rtl/sd_crc16_serial.sv | 26 ++
 rtl/sd_dat_rx_deframer.sv | 177 +++++++++++++++++
 tb/tb_sd_dat_rx_deframer.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/sd_dat_rx_deframer_pkg.sv
// Shared constants, state encoding and CRC16 step for the SD DAT receive path.
package sd_rx_pkg;

  localparam int CRC_W     = 16;
  localparam int DAT_LINES = 4;

  localparam logic [CRC_W-1:0] CRC16_POLY = 16'h1021;

  typedef enum logic [2:0] {
    IDLE,
    WAIT_START,
    DATA,
    CRC,
    END,
    DONE
  } state_t;

  // One bit of the CCITT CRC16 (x^16 + x^12 + x^5 + 1), MSB-first feedback.
  function automatic logic [CRC_W-1:0] crc16_step(input logic [CRC_W-1:0] crc,
                                                  input logic             b);
    logic fb;
    fb = crc[CRC_W-1] ^ b;
    return {crc[CRC_W-2:0], 1'b0} ^ (fb ? CRC16_POLY : '0);
  endfunction

endpackage

// File: rtl/sd_crc16_serial.sv
// One-bit-per-cycle CRC16 generator for a single DAT line.
module sd_crc16_serial
  import sd_rx_pkg::*;
(
  input  logic             wclk,
  input  logic             rst,
  input  logic             i_clr,
  input  logic             i_en,
  input  logic             i_bit,
  output logic [CRC_W-1:0] o_crc
);

  logic [CRC_W-1:0] r_crc;

  // Clear at the start bit, otherwise fold in one data bit per enabled cycle.
  always_ff @(posedge wclk or posedge rst) begin
    // NOTE: state registers use non-blocking (<=) so every flop samples
    // pre-edge values; blocking here would create order-dependent races.
    if (rst)        r_crc <= '0;
    else if (i_clr) r_crc <= '0;
    else if (i_en)  r_crc <= crc16_step(r_crc, i_bit);
  end

  assign o_crc = r_crc;

endmodule

// File: rtl/sd_dat_rx_deframer.sv
// SD read-data deframer: finds the start bit on DAT[3:0], forwards payload
// nibbles to the RX FIFO, checks per-line CRC16 and the end bit, and walks
// through multi-block reads.
module sd_dat_rx_deframer
  import sd_rx_pkg::*;
#(
  parameter int BLK_W       = 12,
  parameter int NB_W        = 8,
  parameter int TIMEOUT_CYC = 65535,
  parameter int TO_W        = 16
) (
  input  logic             wclk,
  input  logic             rst,
  input  logic [3:0]       dat_i,
  input  logic             start,
  input  logic             abort,
  input  logic [BLK_W-1:0] blk_bytes,
  input  logic [NB_W-1:0]  num_blocks,
  input  logic             fifo_full,
  output logic [3:0]       d,
  output logic             wr,
  output logic             busy,
  output logic             blk_done,
  output logic             done,
  output logic             crc_err,
  output logic             end_err,
  output logic             timeout,
  output logic             overrun
);

  state_t           r_state;
  logic [BLK_W-1:0] r_blk_bytes;
  logic [NB_W-1:0]  r_blk_left;
  logic [BLK_W:0]   r_nib_cnt;   // one extra bit: 4092 bytes = 8184 nibbles
  logic [TO_W-1:0]  r_to_cnt;
  logic [3:0]       r_d;
  logic             r_wr_pend;
  logic             r_blk_done;
  logic             r_crc_err;
  logic             r_end_err;
  logic             r_timeout;
  logic             r_overrun;
  logic [CRC_W-1:0] r_rx_crc [DAT_LINES];

  logic [CRC_W-1:0] w_crc [DAT_LINES];
  logic             w_start_ok;
  logic             w_crc_clr;
  logic             w_crc_en;
  logic             w_crc_bad;
  logic [BLK_W:0]   w_nib_last;

  // Only whole 32-bit words and non-empty transfers are accepted.
  assign w_start_ok = (blk_bytes != '0) && (blk_bytes[1:0] == 2'b00) && (num_blocks != '0);
  assign w_nib_last = {r_blk_bytes, 1'b0} - (BLK_W+1)'(1);
  assign w_crc_clr  = (r_state == WAIT_START) && (dat_i == 4'h0);
  assign w_crc_en   = (r_state == DATA);

  for (genvar g = 0; g < DAT_LINES; g++) begin : g_crc
    sd_crc16_serial u_crc (
      .wclk  (wclk),
      .rst   (rst),
      .i_clr (w_crc_clr),
      .i_en  (w_crc_en),
      .i_bit (dat_i[g]),
      .o_crc (w_crc[g])
    );
  end

  // Any line whose received CRC disagrees with the locally computed one.
  always_comb begin
    // NOTE: default assignment first so no path leaves the signal unassigned,
    // which would otherwise infer a latch.
    w_crc_bad = 1'b0;
    for (int i = 0; i < DAT_LINES; i++) begin
      if (r_rx_crc[i] != w_crc[i]) w_crc_bad = 1'b1;
    end
  end

  // Framing FSM, counters, nibble register and sticky status.
  always_ff @(posedge wclk or posedge rst) begin
    if (rst) begin
      r_state     <= IDLE;
      r_blk_bytes <= '0;
      r_blk_left  <= '0;
      r_nib_cnt   <= '0;
      r_to_cnt    <= '0;
      r_d         <= 4'h0;
      r_wr_pend   <= 1'b0;
      r_blk_done  <= 1'b0;
      r_crc_err   <= 1'b0;
      r_end_err   <= 1'b0;
      r_timeout   <= 1'b0;
      r_overrun   <= 1'b0;
      // NOTE: the small received-CRC array is reset like any other register
      // so END never compares against X after a mid-read reset.
      for (int i = 0; i < DAT_LINES; i++) r_rx_crc[i] <= '0;
    end else begin
      r_wr_pend  <= 1'b0;
      r_blk_done <= 1'b0;
      if (r_wr_pend && fifo_full) r_overrun <= 1'b1;

      if ((r_state != IDLE) && abort) begin
        r_state <= IDLE;
      end else begin
        case (r_state)
          IDLE: begin
            if (start && w_start_ok) begin
              r_blk_bytes <= blk_bytes;
              r_blk_left  <= num_blocks;
              r_to_cnt    <= '0;
              r_crc_err   <= 1'b0;
              r_end_err   <= 1'b0;
              r_timeout   <= 1'b0;
              r_overrun   <= 1'b0;
              r_state     <= WAIT_START;
            end
          end
          WAIT_START: begin
            r_to_cnt <= r_to_cnt + TO_W'(1);
            if (dat_i == 4'h0) begin
              r_nib_cnt <= '0;
              r_state   <= DATA;
            end else if (r_to_cnt == TO_W'(TIMEOUT_CYC - 1)) begin
              r_timeout <= 1'b1;
              r_state   <= DONE;
            end
          end
          DATA: begin
            r_d       <= dat_i;
            r_wr_pend <= 1'b1;
            if (r_nib_cnt == w_nib_last) begin
              r_nib_cnt <= '0;
              r_state   <= CRC;
            end else begin
              r_nib_cnt <= r_nib_cnt + (BLK_W+1)'(1);
            end
          end
          CRC: begin
            for (int i = 0; i < DAT_LINES; i++)
              r_rx_crc[i] <= {r_rx_crc[i][CRC_W-2:0], dat_i[i]};
            if (r_nib_cnt == (BLK_W+1)'(CRC_W - 1)) begin
              r_nib_cnt <= '0;
              r_state   <= END;
            end else begin
              r_nib_cnt <= r_nib_cnt + (BLK_W+1)'(1);
            end
          end
          END: begin
            if (dat_i != 4'hF) r_end_err <= 1'b1;
            if (w_crc_bad)     r_crc_err <= 1'b1;
            r_blk_done <= 1'b1;
            if (r_blk_left == NB_W'(1)) begin
              r_state <= DONE;
            end else begin
              r_blk_left <= r_blk_left - NB_W'(1);
              r_to_cnt   <= '0;
              r_state    <= WAIT_START;
            end
          end
          DONE:    r_state <= IDLE;
          default: r_state <= IDLE;
        endcase
      end
    end
  end

  assign d        = r_d;
  assign wr       = r_wr_pend & ~fifo_full;
  assign busy     = (r_state != IDLE);
  assign done     = (r_state == DONE);
  assign blk_done = r_blk_done;
  assign crc_err  = r_crc_err;
  assign end_err  = r_end_err;
  assign timeout  = r_timeout;
  assign overrun  = r_overrun;

endmodule

// File: tb/tb_sd_dat_rx_deframer.sv
// Scoreboard bench for sd_dat_rx_deframer: the driver frames blocks with a
// bench-side CRC16 model and queues expected nibbles; a negedge monitor pops
// and compares every FIFO write.
module tb_sd_dat_rx_deframer;

  localparam int BLK_W = 12;
  localparam int NB_W  = 8;

  logic             wclk;
  logic             rst;
  logic [3:0]       dat_i;
  logic             start;
  logic             abort;
  logic [BLK_W-1:0] blk_bytes;
  logic [NB_W-1:0]  num_blocks;
  logic             fifo_full;
  logic [3:0]       d;
  logic             wr;
  logic             busy;
  logic             blk_done;
  logic             done;
  logic             crc_err;
  logic             end_err;
  logic             timeout;
  logic             overrun;

  int n_checks = 0;
  int n_errors = 0;
  int n_wr = 0;
  int n_blk = 0;
  int n_done = 0;
  int n_busy = 0;

  logic [3:0] exp_q [$];
  logic [7:0] payload [0:4095];

  sd_dat_rx_deframer #(
    .BLK_W       (BLK_W),
    .NB_W        (NB_W),
    .TIMEOUT_CYC (16),
    .TO_W        (16)
  ) dut (
    .wclk       (wclk),
    .rst        (rst),
    .dat_i      (dat_i),
    .start      (start),
    .abort      (abort),
    .blk_bytes  (blk_bytes),
    .num_blocks (num_blocks),
    .fifo_full  (fifo_full),
    .d          (d),
    .wr         (wr),
    .busy       (busy),
    .blk_done   (blk_done),
    .done       (done),
    .crc_err    (crc_err),
    .end_err    (end_err),
    .timeout    (timeout),
    .overrun    (overrun)
  );

  initial wclk = 1'b0;
  always #5 wclk = ~wclk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] model_crc(input logic [15:0] c, input logic b);
    logic fb;
    fb = c[15] ^ b;
    return {c[14:0], 1'b0} ^ (fb ? 16'h1021 : 16'h0000);
  endfunction

  function automatic bit in_range(input int j, input int lo, input int hi);
    return (j >= 0) && (j >= lo) && (j <= hi);
  endfunction

  task automatic tick();
    @(posedge wclk);
    #1;
  endtask

  // Monitor: score every write, count pulses and busy cycles.
  initial begin
    forever begin
      @(negedge wclk);
      if (wr) begin
        n_wr++;
        if (exp_q.size() == 0) check("unexpected_wr", 32'd1, 32'd0);
        else check("nibble", {28'd0, d}, {28'd0, exp_q.pop_front()});
      end
      if (blk_done) n_blk++;
      if (done)     n_done++;
      if (busy)     n_busy++;
    end
  end

  task automatic arm(input int bytes, input int blocks);
    blk_bytes  = BLK_W'(bytes);
    num_blocks = NB_W'(blocks);
    start      = 1'b1;
    tick();
    start      = 1'b0;
  endtask

  // Drive one framed block; nibbles whose write lands under fifo_full are not queued.
  task automatic send_block(input int nbytes, input int flip_line, input int flip_bit,
                            input logic [3:0] end_nib, input int full_lo, input int full_hi,
                            input int idle);
    logic [15:0] mcrc [4];
    logic [3:0]  nib;
    int          last;
    for (int i = 0; i < 4; i++) mcrc[i] = 16'h0;
    last = 2 * nbytes - 1;
    for (int k = 0; k < idle; k++) begin
      dat_i = 4'hF; fifo_full = 1'b0; tick();
    end
    dat_i = 4'h0; tick();
    for (int j = 0; j <= last; j++) begin
      nib = (j % 2 == 0) ? payload[j/2][7:4] : payload[j/2][3:0];
      dat_i     = nib;
      fifo_full = in_range(j - 1, full_lo, full_hi);
      if (!in_range(j, full_lo, full_hi)) exp_q.push_back(nib);
      for (int i = 0; i < 4; i++) mcrc[i] = model_crc(mcrc[i], nib[i]);
      tick();
    end
    for (int k = 0; k < 16; k++) begin
      for (int i = 0; i < 4; i++)
        dat_i[i] = mcrc[i][15-k] ^ ((i == flip_line) && (k == flip_bit));
      fifo_full = (k == 0) && in_range(last, full_lo, full_hi);
      tick();
    end
    dat_i = end_nib; fifo_full = 1'b0; tick();
    dat_i = 4'hF;
  endtask

  task automatic wait_idle(input string tag);
    int k;
    for (k = 0; k < 200; k++) begin
      if (!busy) break;
      tick();
    end
    check(tag, {31'd0, (k < 200)}, 32'd1);
    tick();
  endtask

  int b_wr, b_blk, b_done, b_busy;

  task automatic snap();
    b_wr = n_wr; b_blk = n_blk; b_done = n_done; b_busy = n_busy;
  endtask

  initial begin
    rst = 1'b1; dat_i = 4'hF; start = 1'b0; abort = 1'b0;
    blk_bytes = '0; num_blocks = '0; fifo_full = 1'b0;
    repeat (3) @(posedge wclk);
    #1 rst = 1'b0;
    @(negedge wclk);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_wr", {31'd0, wr}, 32'd0);
    check("rst_d", {28'd0, d}, 32'd0);
    check("rst_flags", {27'd0, done, crc_err, end_err, timeout, overrun}, 32'd0);
    tick();

    // Single 4-byte block, nibbles 1..8.
    payload[0] = 8'h12; payload[1] = 8'h34; payload[2] = 8'h56; payload[3] = 8'h78;
    snap();
    arm(4, 1);
    send_block(4, -1, 0, 4'hF, -1, -1, 2);
    wait_idle("t1_idle");
    check("t1_wr", n_wr - b_wr, 8);
    check("t1_blk", n_blk - b_blk, 1);
    check("t1_done", n_done - b_done, 1);
    check("t1_flags", {28'd0, crc_err, end_err, timeout, overrun}, 32'd0);

    // 512-byte zero block, good then corrupted CRC on line 2.
    for (int i = 0; i < 512; i++) payload[i] = 8'h00;
    snap();
    arm(512, 1);
    send_block(512, -1, 0, 4'hF, -1, -1, 1);
    wait_idle("t2_idle");
    check("t2_wr", n_wr - b_wr, 1024);
    check("t2_crc_err", {31'd0, crc_err}, 32'd0);
    snap();
    arm(512, 1);
    send_block(512, 2, 5, 4'hF, -1, -1, 1);
    wait_idle("t2b_idle");
    check("t2b_crc_err", {31'd0, crc_err}, 32'd1);
    check("t2b_done", n_done - b_done, 1);

    // Three 8-byte blocks with 5 idle cycles before each.
    snap();
    arm(8, 3);
    for (int b = 0; b < 3; b++) begin
      for (int i = 0; i < 8; i++) payload[i] = 8'($urandom);
      send_block(8, -1, 0, 4'hF, -1, -1, 5);
    end
    wait_idle("t3_idle");
    check("t3_blk", n_blk - b_blk, 3);
    check("t3_done", n_done - b_done, 1);
    check("t3_wr", n_wr - b_wr, 48);
    check("t3_crc_err", {31'd0, crc_err}, 32'd0);

    // Timeout: 16 WAIT_START cycles plus the DONE cycle.
    snap();
    arm(4, 1);
    dat_i = 4'hF;
    wait_idle("t4_idle");
    check("t4_timeout", {31'd0, timeout}, 32'd1);
    check("t4_done", n_done - b_done, 1);
    check("t4_wr", n_wr - b_wr, 0);
    check("t4_busy_cycles", n_busy - b_busy, 17);

    // Overrun: fifo_full over nibbles 3-4.
    payload[0] = 8'h12; payload[1] = 8'h34; payload[2] = 8'h56; payload[3] = 8'h78;
    snap();
    arm(4, 1);
    check("t5_timeout_cleared", {31'd0, timeout}, 32'd0);
    send_block(4, -1, 0, 4'hF, 2, 3, 0);
    wait_idle("t5_idle");
    check("t5_wr", n_wr - b_wr, 6);
    check("t5_overrun", {31'd0, overrun}, 32'd1);
    check("t5_crc_err", {31'd0, crc_err}, 32'd0);

    // Bad end nibble.
    snap();
    arm(4, 1);
    send_block(4, -1, 0, 4'hE, -1, -1, 0);
    wait_idle("t6_idle");
    check("t6_end_err", {31'd0, end_err}, 32'd1);
    check("t6_crc_err", {31'd0, crc_err}, 32'd0);
    check("t6_done", n_done - b_done, 1);

    // Abort mid-DATA.
    snap();
    arm(4, 1);
    dat_i = 4'h0; tick();
    for (int j = 0; j < 4; j++) begin
      dat_i = 4'(j + 1); exp_q.push_back(4'(j + 1)); tick();
    end
    dat_i = 4'h5; abort = 1'b1; tick();
    abort = 1'b0; dat_i = 4'hF;
    @(negedge wclk);
    check("t7_busy", {31'd0, busy}, 32'd0);
    check("t7_wr", {31'd0, wr}, 32'd0);
    check("t7_end_err_cleared", {31'd0, end_err}, 32'd0);
    repeat (4) tick();
    check("t7_done", n_done - b_done, 0);
    check("t7_blk", n_blk - b_blk, 0);
    check("t7_wr_cnt", n_wr - b_wr, 4);

    // start and abort together in IDLE: start wins.
    blk_bytes = 12'd4; num_blocks = 8'd1; start = 1'b1; abort = 1'b1; tick();
    start = 1'b0; abort = 1'b0;
    @(negedge wclk);
    check("t8_busy", {31'd0, busy}, 32'd1);
    tick();
    abort = 1'b1; tick(); abort = 1'b0;
    @(negedge wclk);
    check("t8_aborted", {31'd0, busy}, 32'd0);
    tick();

    // Illegal block length is ignored.
    snap();
    arm(6, 1);
    repeat (5) tick();
    check("t9_ignored", n_busy - b_busy, 0);

    check("queue_empty", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
